// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan receiver:
// segment patterns {a..g}, BCD codes for blank/invalid digits and FSM states.
package seg_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1110011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_ERR   = 4'hE;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_e;

endpackage

// File: rtl/seg_dec.sv
// Combinational seven-segment to BCD decoder. Unlit pattern decodes to the
// blank code; anything that is not a known digit decodes to the error code.
module seg_dec
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_bcd
);

    // Pattern lookup against the shared segment constants
    always_comb begin
        case (i_seg)
            SEG_0:     o_bcd = 4'd0;
            SEG_1:     o_bcd = 4'd1;
            SEG_2:     o_bcd = 4'd2;
            SEG_3:     o_bcd = 4'd3;
            SEG_4:     o_bcd = 4'd4;
            SEG_5:     o_bcd = 4'd5;
            SEG_6:     o_bcd = 4'd6;
            SEG_7:     o_bcd = 4'd7;
            SEG_8:     o_bcd = 4'd8;
            SEG_9:     o_bcd = 4'd9;
            SEG_BLANK: o_bcd = BCD_BLANK;
            default:   o_bcd = BCD_ERR;
        endcase
    end

endmodule

// File: rtl/seg_scan_rx.sv
// Receive-side monitor for a scanned six-digit seven-segment bus.
// Synchronizes the bus, waits for each digit enable to settle, decodes the
// segment lines into a shadow frame and publishes complete, in-order frames.
// Optional feature: define SEG_SCAN_RX_DP_EN to capture the decimal point per
// digit into o_dp; otherwise o_dp is constant zero and i_seg_dp is ignored.
module seg_scan_rx
    import seg_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 120000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  i_seg,
    input  logic        i_seg_dp,
    input  logic [5:0]  i_seg_enb,
    output logic [23:0] o_digits,
    output logic [5:0]  o_dp,
    output logic        o_frame_vld,
    output logic        o_frame_err,
    output logic        o_seq_err,
    output logic        o_locked
);

    localparam int               TMO_W      = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX    = TMO_W'(TIMEOUT);
    localparam logic [7:0]       SETTLE_MAX = 8'(SETTLE);
    localparam logic [7:0]       SETTLE_M1  = 8'(SETTLE - 1);
    localparam logic [2:0]       LAST_IDX   = 3'(NUM_DIGITS - 1);

    logic [6:0]       seg_s1_q, seg_s_q;
    logic [5:0]       enb_s1_q, enb_s_q, enb_last_q;
    logic [7:0]       settle_q, settle_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    state_e           state_q, state_d;
    logic [2:0]       expect_q, expect_d;
    logic             locked_q, locked_d;
    logic             vld_q, vld_d;
    logic             ferr_q, ferr_d;
    logic             seq_q, seq_d;
    logic [23:0]      shadow_q, shadow_d;
    logic [23:0]      digits_q, digits_d;

    logic [5:0]       enb_low;
    logic             enb_change;
    logic             cap_fire;
    logic             one_low;
    logic             multi_low;
    logic             valid_cap;
    logic [2:0]       cap_idx;
    logic [3:0]       cap_bcd;
    logic             wr_en;
    logic             frame_done;

    seg_dec u_dec (
        .i_seg (seg_s_q),
        .o_bcd (cap_bcd)
    );

    // Settle tracking: one capture per stable enable value, classified by
    // how many enables are low
    always_comb begin
        enb_low    = ~enb_s_q;
        enb_change = (enb_s_q != enb_last_q);
        cap_fire   = !enb_change && (settle_q == SETTLE_M1);
        one_low    = (enb_low != 6'd0) && ((enb_low & (enb_low - 6'd1)) == 6'd0);
        multi_low  = (enb_low != 6'd0) && !one_low;
        valid_cap  = cap_fire && one_low;
        cap_idx    = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (enb_low[i]) cap_idx = 3'(i);
        end
        if (enb_change)
            settle_d = 8'd0;
        else if (settle_q == SETTLE_MAX)
            settle_d = SETTLE_MAX;
        else
            settle_d = settle_q + 8'd1;
    end

    // Frame FSM and timeout; a valid capture always beats a timeout
    always_comb begin
        state_d    = state_q;
        expect_d   = expect_q;
        locked_d   = locked_q;
        tmo_d      = tmo_q;
        seq_d      = 1'b0;
        wr_en      = 1'b0;
        frame_done = 1'b0;

        if (valid_cap) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + TMO_W'(1);
            if (tmo_d == TMO_MAX) begin
                locked_d = 1'b0;
                state_d  = HUNT;
            end
        end

        if (cap_fire && multi_low) begin
            seq_d    = 1'b1;
            locked_d = 1'b0;
            state_d  = HUNT;
        end else if (valid_cap) begin
            case (state_q)
                HUNT: begin
                    if (cap_idx == 3'd0) begin
                        wr_en    = 1'b1;
                        expect_d = 3'd1;
                        state_d  = COLLECT;
                    end
                end
                COLLECT: begin
                    if (cap_idx == expect_q) begin
                        wr_en = 1'b1;
                        if (cap_idx == LAST_IDX) begin
                            frame_done = 1'b1;
                            locked_d   = 1'b1;
                            expect_d   = 3'd0;
                        end else begin
                            expect_d = expect_q + 3'd1;
                        end
                    end else begin
                        // Out of order: drop the partial frame; a digit 0
                        // immediately starts a fresh one
                        seq_d    = 1'b1;
                        locked_d = 1'b0;
                        if (cap_idx == 3'd0) begin
                            wr_en    = 1'b1;
                            expect_d = 3'd1;
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        vld_d = frame_done;
    end

    // Shadow frame fill and publication of complete frames only
    always_comb begin
        shadow_d = shadow_q;
        if (wr_en) shadow_d[{cap_idx, 2'b00} +: 4] = cap_bcd;
        digits_d = frame_done ? shadow_d : digits_q;
        ferr_d   = 1'b0;
        if (frame_done) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (shadow_d[i*4 +: 4] == BCD_ERR) ferr_d = 1'b1;
            end
        end
    end

    // State registers, including the two-flop bus synchronizers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q   <= SEG_BLANK;
            seg_s_q    <= SEG_BLANK;
            enb_s1_q   <= '1;
            enb_s_q    <= '1;
            enb_last_q <= '1;
            settle_q   <= '0;
            tmo_q      <= '0;
            state_q    <= HUNT;
            expect_q   <= '0;
            locked_q   <= 1'b0;
            vld_q      <= 1'b0;
            ferr_q     <= 1'b0;
            seq_q      <= 1'b0;
            shadow_q   <= {NUM_DIGITS{BCD_BLANK}};
            digits_q   <= {NUM_DIGITS{BCD_BLANK}};
        end else begin
            seg_s1_q   <= i_seg;
            seg_s_q    <= seg_s1_q;
            enb_s1_q   <= i_seg_enb;
            enb_s_q    <= enb_s1_q;
            enb_last_q <= enb_s_q;
            settle_q   <= settle_d;
            tmo_q      <= tmo_d;
            state_q    <= state_d;
            expect_q   <= expect_d;
            locked_q   <= locked_d;
            vld_q      <= vld_d;
            ferr_q     <= ferr_d;
            seq_q      <= seq_d;
            shadow_q   <= shadow_d;
            digits_q   <= digits_d;
        end
    end

`ifdef SEG_SCAN_RX_DP_EN
    logic       dp_s1_q, dp_s_q;
    logic [5:0] dp_shadow_q, dp_shadow_d;
    logic [5:0] dp_out_q, dp_out_d;

    // Decimal points follow the same shadow/publish path as the digits
    always_comb begin
        dp_shadow_d = dp_shadow_q;
        if (wr_en) dp_shadow_d[cap_idx] = dp_s_q;
        dp_out_d = frame_done ? dp_shadow_d : dp_out_q;
    end

    // Decimal point synchronizer and holding registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_s1_q     <= 1'b0;
            dp_s_q      <= 1'b0;
            dp_shadow_q <= '0;
            dp_out_q    <= '0;
        end else begin
            dp_s1_q     <= i_seg_dp;
            dp_s_q      <= dp_s1_q;
            dp_shadow_q <= dp_shadow_d;
            dp_out_q    <= dp_out_d;
        end
    end

    assign o_dp = dp_out_q;
`else
    logic unused_dp;
    assign unused_dp = i_seg_dp;
    assign o_dp      = 6'd0;
`endif

    assign o_digits    = digits_q;
    assign o_frame_vld = vld_q;
    assign o_frame_err = ferr_q;
    assign o_seq_err   = seq_q;
    assign o_locked    = locked_q;

endmodule

// File: tb/tb_seg_scan_rx.sv
// Bench for seg_scan_rx: directed scenarios with literal expectations plus
// randomized scanning, all checked every cycle against a frame-level model.
module tb_seg_scan_rx;

    localparam int SETTLE_T  = 4;
    localparam int TIMEOUT_T = 500;
    localparam int D         = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  i_seg = 7'd0;
    logic        i_seg_dp = 1'b0;
    logic [5:0]  i_seg_enb = 6'h3F;
    logic [23:0] o_digits;
    logic [5:0]  o_dp;
    logic        o_frame_vld, o_frame_err, o_seq_err, o_locked;

    always #5 clk = ~clk;

    seg_scan_rx #(.SETTLE(SETTLE_T), .TIMEOUT(TIMEOUT_T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_seg       (i_seg),
        .i_seg_dp    (i_seg_dp),
        .i_seg_enb   (i_seg_enb),
        .o_digits    (o_digits),
        .o_dp        (o_dp),
        .o_frame_vld (o_frame_vld),
        .o_frame_err (o_frame_err),
        .o_seq_err   (o_seq_err),
        .o_locked    (o_locked)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1110011};

    function automatic logic [3:0] ref_dec(input logic [6:0] s);
        logic [3:0] r;
        r = (s == 7'd0) ? 4'hF : 4'hE;
        for (int d = 0; d < 10; d++) if (seg_tab[d] == s) r = 4'(d);
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        int         due;
        logic [5:0] enb;
        logic [6:0] seg;
        logic       dp;
    } cap_t;

    cap_t       evq[$];
    logic [3:0] m_dig[$];
    logic       m_dpq[$];
    int         cyc = 0;
    logic [5:0] m_last_enb;
    int         m_run;
    int         m_timer;
    logic       m_hunt, m_locked;
    logic [23:0] e_digits;
    logic [5:0]  e_dp;
    logic        e_vld, e_ferr, e_seq;

    task automatic model_reset();
        evq.delete(); m_dig.delete(); m_dpq.delete();
        m_last_enb = 6'h3F; m_run = 1000; m_timer = 0;
        m_hunt = 1'b1; m_locked = 1'b0;
        e_digits = 24'hFFFFFF; e_dp = 6'd0; e_vld = 1'b0; e_ferr = 1'b0; e_seq = 1'b0;
    endtask

    task automatic deliver();
        e_vld = 1'b1; e_ferr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            e_digits[i*4 +: 4] = m_dig[i];
            if (m_dig[i] == 4'hE) e_ferr = 1'b1;
`ifdef SEG_SCAN_RX_DP_EN
            e_dp[i] = m_dpq[i];
`else
            e_dp[i] = 1'b0;
`endif
        end
        m_locked = 1'b1;
        m_dig.delete(); m_dpq.delete();
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            bit valid;
            cyc++;
            e_vld = 1'b0; e_ferr = 1'b0; e_seq = 1'b0;
            valid = 1'b0;
            if (evq.size() > 0 && evq[0].due == cyc) begin
                cap_t ev;
                int   nlow, idx;
                ev = evq.pop_front();
                nlow = $countones(~ev.enb);
                idx = 0;
                for (int i = 0; i < 6; i++) if (!ev.enb[i]) idx = i;
                if (nlow >= 2) begin
                    e_seq = 1'b1; m_locked = 1'b0; m_hunt = 1'b1;
                    m_dig.delete(); m_dpq.delete();
                end else if (nlow == 1) begin
                    valid = 1'b1;
                    if (m_hunt) begin
                        if (idx == 0) begin
                            m_dig.push_back(ref_dec(ev.seg)); m_dpq.push_back(ev.dp); m_hunt = 1'b0;
                        end
                    end else if (idx == m_dig.size()) begin
                        m_dig.push_back(ref_dec(ev.seg)); m_dpq.push_back(ev.dp);
                        if (m_dig.size() == 6) deliver();
                    end else begin
                        e_seq = 1'b1; m_locked = 1'b0;
                        m_dig.delete(); m_dpq.delete();
                        if (idx == 0) begin
                            m_dig.push_back(ref_dec(ev.seg)); m_dpq.push_back(ev.dp);
                        end else begin
                            m_hunt = 1'b1;
                        end
                    end
                end
            end
            if (valid) m_timer = 0;
            else if (m_timer < TIMEOUT_T) begin
                m_timer++;
                if (m_timer == TIMEOUT_T) begin
                    m_locked = 1'b0; m_hunt = 1'b1; m_dig.delete(); m_dpq.delete();
                end
            end
            // A pin value first seen at edge k and held SETTLE+1 samples is
            // captured 2 synchronizer cycles later
            if (i_seg_enb == m_last_enb) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run = 1; m_last_enb = i_seg_enb;
            end
            if (m_run == SETTLE_T + 1)
                evq.push_back('{cyc + 2, i_seg_enb, i_seg, i_seg_dp});
        end
    end

    // ---------------- compare and event tracking ----------------
    int          dut_frames = 0, dut_seq = 0;
    logic [23:0] dut_last_digits = 24'h0;
    logic        dut_last_ferr = 1'b0;
    int          t_prev_vld = 0, t_last_vld = 0, t_lock_rise = 0, t_lock_fall = 0;
    logic        lock_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            lock_prev = 1'b0;
        end else begin
            chk("digits",    32'(o_digits),    32'(e_digits));
            chk("dp",        32'(o_dp),        32'(e_dp));
            chk("frame_vld", 32'(o_frame_vld), 32'(e_vld));
            chk("frame_err", 32'(o_frame_err), 32'(e_ferr));
            chk("seq_err",   32'(o_seq_err),   32'(e_seq));
            chk("locked",    32'(o_locked),    32'(m_locked));
            if (o_frame_vld) begin
                dut_frames++; dut_last_digits = o_digits; dut_last_ferr = o_frame_err;
                t_prev_vld = t_last_vld; t_last_vld = cyc;
            end
            if (o_seq_err) dut_seq++;
            if (o_locked && !lock_prev) t_lock_rise = cyc;
            if (!o_locked && lock_prev) t_lock_fall = cyc;
            lock_prev = o_locked;
        end
    end

    // ---------------- stimulus ----------------
    logic [6:0] pat_seg [6];
    logic       pat_dp  [6];

    task automatic drive(input logic [5:0] enb, input logic [6:0] seg, input logic dp, input int n);
        i_seg_enb = enb; i_seg = seg; i_seg_dp = dp;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan_idx(input int idx, input int n);
        drive(~(6'd1 << idx), pat_seg[idx], pat_dp[idx], n);
    endtask

    task automatic scan_all(input int n);
        for (int i = 0; i < 6; i++) scan_idx(i, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, s0;
        for (int i = 0; i < 6; i++) begin pat_seg[i] = 7'd0; pat_dp[i] = 1'b0; end
        pat_seg[0] = 7'b1110000;  // 7
        pat_seg[1] = 7'b1111001;  // 3
        pat_dp[1]  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_digits", 32'(o_digits), 32'h00FFFFFF);
        chk("rst_locked", 32'(o_locked), 32'd0);
        chk("rst_vld",    32'(o_frame_vld), 32'd0);
        chk("rst_seq",    32'(o_seq_err), 32'd0);
        chk("rst_dp",     32'(o_dp), 32'd0);

        // Display "37": two full scans, two frames, fixed period
        f0 = dut_frames;
        scan_all(D);
        scan_all(D);
        chk("f37_count",  32'(dut_frames - f0), 32'd2);
        chk("f37_digits", 32'(dut_last_digits), 32'h00FFFF37);
        chk("f37_err",    32'(dut_last_ferr), 32'd0);
        chk("f37_locked", 32'(o_locked), 32'd1);
        chk("f37_period", 32'(t_last_vld - t_prev_vld), 32'(6 * D));

        // Invalid pattern on digit 3 is still delivered, flagged
        pat_seg[3] = 7'b1010101;
        scan_all(D);
        chk("err_digits", 32'(dut_last_digits), 32'h00FFEF37);
        chk("err_flag",   32'(dut_last_ferr), 32'd1);
        pat_seg[3] = 7'd0;

        // Order 0,1,3: sequence error, no frame until a clean 0..5
        s0 = dut_seq; f0 = dut_frames;
        scan_idx(0, D); scan_idx(1, D); scan_idx(3, D); scan_idx(4, D); scan_idx(5, D);
        chk("order_seq",    32'(dut_seq - s0), 32'd1);
        chk("order_locked", 32'(o_locked), 32'd0);
        chk("order_frames", 32'(dut_frames - f0), 32'd0);
        scan_all(D);
        chk("order_recover", 32'(dut_frames - f0), 32'd1);

        // Short glitch on index 2 then two enables low
        s0 = dut_seq; f0 = dut_frames;
        scan_idx(0, D); scan_idx(1, D); scan_idx(2, 2);
        drive(6'b111100, 7'd0, 1'b0, D);
        chk("glitch_seq",    32'(dut_seq - s0), 32'd1);
        chk("glitch_locked", 32'(o_locked), 32'd0);
        chk("glitch_frames", 32'(dut_frames - f0), 32'd0);

        // Lock, then freeze the bus blank past the timeout
        scan_all(D);
        drive(6'h3F, 7'd0, 1'b0, TIMEOUT_T + 20);
        chk("tmo_span",   32'(t_lock_fall - t_lock_rise), 32'(TIMEOUT_T));
        chk("tmo_locked", 32'(o_locked), 32'd0);
        chk("tmo_hold",   32'(o_digits), 32'h00FFFF37);

        // Asynchronous reset in the middle of a frame
        scan_all(D);
        scan_idx(0, D); scan_idx(1, D); scan_idx(2, D / 2);
        i_seg_enb = 6'h3F; i_seg = 7'd0; i_seg_dp = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_digits", 32'(o_digits), 32'h00FFFFFF);
        chk("arst_locked", 32'(o_locked), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Randomized scanning with order faults, glitches, multi-low, gaps
        for (int f = 0; f < 60; f++) begin
            for (int i = 0; i < 6; i++) begin
                int r, idx, a, b;
                logic [6:0] s;
                r = int'($urandom_range(0, 99));
                idx = (r < 8) ? int'($urandom_range(0, 5)) : i;
                r = int'($urandom_range(0, 99));
                if (r < 70)      s = seg_tab[$urandom_range(0, 9)];
                else if (r < 85) s = 7'd0;
                else             s = 7'($urandom);
                r = int'($urandom_range(0, 99));
                if (r < 5) begin
                    drive(~(6'd1 << $urandom_range(0, 5)), 7'($urandom), 1'($urandom),
                          int'($urandom_range(1, SETTLE_T)));
                end else if (r < 8) begin
                    a = int'($urandom_range(0, 5));
                    b = (a + 1 + int'($urandom_range(0, 4))) % 6;
                    drive(~((6'd1 << a) | (6'd1 << b)), s, 1'b0, int'($urandom_range(8, 20)));
                end
                drive(~(6'd1 << idx), s, 1'($urandom), int'($urandom_range(8, 40)));
                r = int'($urandom_range(0, 3));
                if (r > 0) drive(6'h3F, 7'd0, 1'b0, r);
            end
            if (f % 20 == 19) drive(6'h3F, 7'd0, 1'b0, TIMEOUT_T + 10);
        end
        drive(6'h3F, 7'd0, 1'b0, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
